// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and types for the PS/2 key event sequencer
//
// Purpose: byte constants for prefixes and discardable bytes, FSM state enum,
//          ev_data bit positions and the 10-bit key event record.
// Ports:   none (package).
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_EXT1   = 8'hE1;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam int EV_VALID_BIT = 31;
  localparam int EV_LOST_BIT  = 30;
  localparam int EV_EXT_BIT   = 9;
  localparam int EV_BRK_BIT   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Controller replies and error codes carry no key information.
  function automatic logic is_discard(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// rtl/ps2_key_ctrl_if.sv - receiver-side and CPU-side signal bundle of the key sequencer
//
// Purpose: groups the ps2_kbd pop handshake and the CPU event read port.
// Ports:   kbd_ready/kbd_data/kbd_overflow/kbd_rdn (receiver side),
//          ev_rd/ev_data/ev_count/irq (CPU side).
//          slave  = sequencer view, master = receiver/CPU view.
interface ps2_key_ctrl_if #(
  parameter int DEPTH = 4
);
  logic                     kbd_ready;
  logic [7:0]               kbd_data;
  logic                     kbd_overflow;
  logic                     kbd_rdn;
  logic                     ev_rd;
  logic [31:0]              ev_data;
  logic [$clog2(DEPTH):0]   ev_count;
  logic                     irq;

  modport slave (
    input  kbd_ready, kbd_data, kbd_overflow, ev_rd,
    output kbd_rdn, ev_data, ev_count, irq
  );

  modport master (
    output kbd_ready, kbd_data, kbd_overflow, ev_rd,
    input  kbd_rdn, ev_data, ev_count, irq
  );
endinterface

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - DEPTH x 10-bit show-ahead event FIFO
//
// Purpose: holds decoded key events; head is visible combinationally on dout.
// Ports:   clk, clrn (async active-low), push/din, pop/dout, count, full, empty.
//          A push while full only succeeds when a pop happens in the same cycle.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   push,
  input  ps2_event_t             din,
  input  logic                   pop,
  output ps2_event_t             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  ps2_event_t       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - folds PS/2 prefix bytes into key events for the CPU
//
// Purpose: pops bytes from ps2_kbd (IDLE->POP->GAP), merges E0/F0 prefixes into
//          {ext, brk, code} events, queues them and presents the head as a
//          status word; irq while events are pending.
// Ports:   clk, clrn (async active-low), bus (ps2_key_ctrl_if.slave).
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           clrn,
  ps2_key_ctrl_if.slave  bus
);
  state_t                 state;
  state_t                 state_nx;
  logic [7:0]             byte_r;
  logic                   ext_pend;
  logic                   brk_pend;
  logic                   lost;
  logic                   rdn_r;

  logic                   set_ext;
  logic                   set_brk;
  logic                   clr_pend;
  logic                   key_push;
  logic                   lost_set;

  ps2_event_t             ev_in;
  ps2_event_t             ev_head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [31:0]            ev_word;

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state; GAP ignores kbd_ready because it may still show the popped byte.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.kbd_ready) state_nx = POP;
      POP:     state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Decode of the popped byte, active only in POP
  always_comb begin
    set_ext  = 1'b0;
    set_brk  = 1'b0;
    clr_pend = 1'b0;
    key_push = 1'b0;
    if (state == POP) begin
      if (byte_r == PS2_EXT || byte_r == PS2_EXT1) begin
        set_ext = 1'b1;
      end else if (byte_r == PS2_BRK) begin
        set_brk = 1'b1;
      end else if (is_discard(byte_r)) begin
        clr_pend = 1'b1;
      end else begin
        key_push = 1'b1;
        clr_pend = 1'b1;
      end
    end
  end

  assign fifo_pop = bus.ev_rd && !fifo_empty;
  assign lost_set = bus.kbd_overflow || (key_push && fifo_full && !fifo_pop);
  assign ev_in    = '{ext: ext_pend, brk: brk_pend, code: byte_r};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      byte_r   <= '0;
      rdn_r    <= 1'b1;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      lost     <= 1'b0;
    end else begin
      if (state == IDLE && bus.kbd_ready) byte_r <= bus.kbd_data;
      // Low for exactly the POP cycle.
      rdn_r <= (state_nx != POP);
      if (clr_pend) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else begin
        if (set_ext) ext_pend <= 1'b1;
        if (set_brk) brk_pend <= 1'b1;
      end
      if (lost_set)      lost <= 1'b1;
      else if (fifo_pop) lost <= 1'b0;
    end
  end

  ps2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (key_push),
    .din   (ev_in),
    .pop   (fifo_pop),
    .dout  (ev_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    ev_word               = '0;
    ev_word[EV_VALID_BIT] = !fifo_empty;
    ev_word[EV_LOST_BIT]  = lost;
    if (!fifo_empty) ev_word[EV_EXT_BIT:0] = ev_head;
  end

  assign bus.kbd_rdn  = rdn_r;
  assign bus.ev_data  = ev_word;
  assign bus.ev_count = fifo_count;
  assign bus.irq      = !fifo_empty;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb/tb_ps2_key_ctrl.sv - self-checking bench for ps2_key_ctrl
module tb_ps2_key_ctrl;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic clrn;
  int   n_checks;
  int   n_fail;

  ps2_key_ctrl_if #(.DEPTH(DEPTH)) bus ();

  ps2_key_ctrl #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and reference state
  logic [9:0] exp_q [$];
  logic       m_ext;
  logic       m_brk;
  logic       m_lost;

  // kbd_rdn pulse monitor
  int   rdn_pulses;
  int   rdn_double;
  logic rdn_prev_low;

  always @(negedge clk) begin
    if (bus.kbd_rdn === 1'b0) begin
      if (rdn_prev_low) rdn_double++;
      else              rdn_pulses++;
    end
    rdn_prev_low = (bus.kbd_rdn === 1'b0);
  end

  function automatic logic [31:0] exp_word();
    logic [31:0] w;
    w = '0;
    w[30] = m_lost;
    if (exp_q.size() > 0) begin
      w[31]  = 1'b1;
      w[9:0] = exp_q[0];
    end
    return w;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_lost = 1'b0;
  endfunction

  // Reference decode of one popped byte; rd means ev_rd coincides with the push edge.
  function automatic void model_byte(input logic [7:0] b, input bit rd);
    bit popped;
    bit set;
    popped = rd && (exp_q.size() > 0);
    set    = 1'b0;
    if (popped) void'(exp_q.pop_front());
    if (b == 8'hE0 || b == 8'hE1) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
      else set = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    if (set)         m_lost = 1'b1;
    else if (popped) m_lost = 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rd_same);
    int guard;
    @(negedge clk);
    bus.kbd_ready = 1'b1;
    bus.kbd_data  = b;
    guard = 0;
    while (bus.kbd_rdn !== 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL rdn_timeout: byte %h never popped (kbd_rdn=%b, required 0)", b, bus.kbd_rdn);
      bus.kbd_ready = 1'b0;
      return;
    end
    // Now in the POP cycle: the receiver drops the byte at the next edge.
    bus.kbd_ready = 1'b0;
    if (rd_same) begin
      n_checks++;
      if (bus.ev_data !== exp_word()) begin
        n_fail++;
        $display("FAIL same_cycle_head: got %h required %h", bus.ev_data, exp_word());
      end
      bus.ev_rd = 1'b1;
    end
    model_byte(b, rd_same);
    @(negedge clk);
    bus.ev_rd = 1'b0;
  endtask

  task automatic read_event();
    logic [31:0] w;
    @(negedge clk);
    w = exp_word();
    n_checks++;
    if (bus.ev_data !== w) begin
      n_fail++;
      $display("FAIL read_data: got %h required %h", bus.ev_data, w);
    end
    n_checks++;
    if (bus.ev_count !== CW'(exp_q.size()) || bus.irq !== (exp_q.size() != 0)) begin
      n_fail++;
      $display("FAIL read_count: count %0d irq %b required count %0d", bus.ev_count, bus.irq, exp_q.size());
    end
    bus.ev_rd = 1'b1;
    @(negedge clk);
    bus.ev_rd = 1'b0;
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      m_lost = 1'b0;
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) read_event();
  endtask

  task automatic test_reset();
    bus.kbd_ready    = 1'b0;
    bus.kbd_data     = 8'h00;
    bus.kbd_overflow = 1'b0;
    bus.ev_rd        = 1'b0;
    clrn             = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.ev_data !== 32'h0 || bus.irq !== 1'b0 || bus.kbd_rdn !== 1'b1 || bus.ev_count !== '0) begin
        n_fail++;
        $display("FAIL reset_idle: ev_data %h irq %b rdn %b count %0d required 0/0/1/0",
                 bus.ev_data, bus.irq, bus.kbd_rdn, bus.ev_count);
      end
    end
  endtask

  task automatic test_make_break();
    rdn_pulses = 0;
    send_byte(8'h1C, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.ev_data !== 32'h8000_001C || bus.ev_count !== CW'(2)) begin
      n_fail++;
      $display("FAIL make_head: got %h count %0d required 8000001c count 2", bus.ev_data, bus.ev_count);
    end
    read_event();
    n_checks++;
    if (bus.ev_data !== 32'h8000_011C) begin
      n_fail++;
      $display("FAIL break_head: got %h required 8000011c", bus.ev_data);
    end
    read_event();
    n_checks++;
    if (rdn_pulses !== 3) begin
      n_fail++;
      $display("FAIL rdn_pulses: got %0d required 3", rdn_pulses);
    end
  endtask

  task automatic test_ext_break();
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.ev_data[9:0] !== 10'h375) begin
      n_fail++;
      $display("FAIL ext_break: got %h required 375", bus.ev_data[9:0]);
    end
    drain();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hFA, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.ev_data !== 32'h0 || bus.ev_count !== '0) begin
      n_fail++;
      $display("FAIL discard: ev_data %h count %0d required 0/0", bus.ev_data, bus.ev_count);
    end
    // A discarded byte also cancels a pending prefix.
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'h5A, 1'b0);
    drain();
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    for (int i = 0; i < 5; i++) send_byte(codes[i], 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.ev_count !== CW'(4) || bus.ev_data[30] !== 1'b1 || bus.ev_data[7:0] !== 8'h15) begin
      n_fail++;
      $display("FAIL overflow: count %0d lost %b head %h required 4/1/15",
               bus.ev_count, bus.ev_data[30], bus.ev_data[7:0]);
    end
    read_event();
    @(negedge clk);
    n_checks++;
    if (bus.ev_data[30] !== 1'b0) begin
      n_fail++;
      $display("FAIL lost_clear: got %b required 0", bus.ev_data[30]);
    end
    drain();
  endtask

  task automatic test_full_same_cycle();
    logic [7:0] codes [5];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    for (int i = 0; i < 4; i++) send_byte(codes[i], 1'b0);
    send_byte(codes[4], 1'b1);
    @(negedge clk);
    n_checks++;
    if (bus.ev_count !== CW'(4) || bus.ev_data[30] !== 1'b0 || bus.ev_data[7:0] !== 8'h1E) begin
      n_fail++;
      $display("FAIL full_same_cycle: count %0d lost %b head %h required 4/0/1e",
               bus.ev_count, bus.ev_data[30], bus.ev_data[7:0]);
    end
    drain();
  endtask

  task automatic test_kbd_overflow();
    @(negedge clk);
    bus.kbd_overflow = 1'b1;
    @(negedge clk);
    bus.kbd_overflow = 1'b0;
    m_lost = 1'b1;
    n_checks++;
    if (bus.ev_data !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL kbd_overflow: got %h required 40000000", bus.ev_data);
    end
    send_byte(8'h3C, 1'b0);
    drain();
  endtask

  task automatic test_reset_mid_pop();
    int guard;
    send_byte(8'h33, 1'b0);
    send_byte(8'hF0, 1'b0);
    @(negedge clk);
    bus.kbd_ready = 1'b1;
    bus.kbd_data  = 8'h1C;
    guard = 0;
    while (bus.kbd_rdn !== 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.kbd_ready = 1'b0;
    #1 clrn = 1'b0;
    #1;
    n_checks++;
    if (guard >= 20 || bus.kbd_rdn !== 1'b1 || bus.ev_count !== '0 || bus.ev_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_pop: rdn %b count %0d ev_data %h guard %0d required 1/0/0",
               bus.kbd_rdn, bus.ev_count, bus.ev_data, guard);
    end
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
    send_byte(8'h1C, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.ev_data !== 32'h8000_001C) begin
      n_fail++;
      $display("FAIL post_reset_decode: got %h required 8000001c", bus.ev_data);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] stream [8];
    stream = '{8'hE0, 8'h70, 8'hF0, 8'h71, 8'h29, 8'hE1, 8'hF0, 8'h11};
    for (int i = 0; i < 8; i++) send_byte(stream[i], 1'b0);
    drain();
    read_event();
    n_checks++;
    if (rdn_double !== 0) begin
      n_fail++;
      $display("FAIL rdn_width: %0d double-wide pulses, required 0", rdn_double);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rdn_pulses   = 0;
    rdn_double   = 0;
    rdn_prev_low = 1'b0;
    model_reset();
    test_reset();
    test_make_break();
    test_ext_break();
    test_overflow();
    test_full_same_cycle();
    test_kbd_overflow();
    test_reset_mid_pop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
